// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: owns the PC, one outstanding memory read,
// holds each fetched instruction until decode accepts it, then redirects or halts.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   input  logic        mem_req_ready,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        jump,
   input  logic [31:0] jump_addr,
   input  logic        stop,
   output logic        halted,
   output logic [31:0] retire_cnt
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_HOLD = 3'd3;
   localparam logic [2:0] S_HALT = 3'd4;

   logic [2:0]  r_state;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic [31:0] r_inst_pc;
   logic [31:0] r_retire_cnt;
   logic        r_req_valid;
   logic        r_inst_valid;
   logic        r_halted;

   logic [2:0]  w_state_nxt;
   logic        w_req_fire;
   logic        w_resp_take;
   logic        w_accept;
   logic [31:0] w_pc_nxt;
   logic        w_unused;

   assign w_req_fire  = (r_state == S_REQ)  & mem_req_ready;
   assign w_resp_take = (r_state == S_WAIT) & mem_resp_valid;
   assign w_accept    = (r_state == S_HOLD) & inst_ready;

   // Instructions are word aligned (no compressed ISA), so the redirect's low bits are dropped.
   assign w_pc_nxt = jump ? {jump_addr[31:2], 2'b00} : r_pc + 32'd4;
   assign w_unused = ^jump_addr[1:0];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = S_REQ;
         S_REQ:   if (w_req_fire)  w_state_nxt = S_WAIT;
         S_WAIT:  if (w_resp_take) w_state_nxt = S_HOLD;
         S_HOLD:  if (w_accept)    w_state_nxt = stop ? S_HALT : S_REQ;
         S_HALT:  w_state_nxt = S_HALT;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Handshake flags are registered from the next state so every output comes straight off a flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_req_valid  <= 1'b0;
         r_inst_valid <= 1'b0;
         r_halted     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_req_valid  <= (w_state_nxt == S_REQ);
         r_inst_valid <= (w_state_nxt == S_HOLD);
         r_halted     <= (w_state_nxt == S_HALT);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc         <= RESET_PC;
         r_inst       <= 32'd0;
         r_inst_pc    <= 32'd0;
         r_retire_cnt <= 32'd0;
      end else begin
         if (w_resp_take) begin
            r_inst    <= mem_resp_data;
            r_inst_pc <= r_pc;
         end
         if (w_accept) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
            if (!stop) r_pc <= w_pc_nxt;
         end
      end
   end

   assign mem_req_valid = r_req_valid;
   assign mem_req_addr  = r_pc;
   assign inst_valid    = r_inst_valid;
   assign inst          = r_inst;
   assign inst_pc       = r_inst_pc;
   assign halted        = r_halted;
   assign retire_cnt    = r_retire_cnt;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch: directed scenarios plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_ifu_fetch;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk;
   logic        rst;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        jump;
   logic [31:0] jump_addr;
   logic        stop;
   logic        halted;
   logic [31:0] retire_cnt;

   int n_total = 0;
   int n_pass  = 0;

   logic spur_en;
   int   max_extra;

   ifu_fetch #(.RESET_PC(RST_PC)) dut (
      .clk(clk),
      .rst(rst),
      .mem_req_valid(mem_req_valid),
      .mem_req_addr(mem_req_addr),
      .mem_req_ready(mem_req_ready),
      .mem_resp_valid(mem_resp_valid),
      .mem_resp_data(mem_resp_data),
      .inst_valid(inst_valid),
      .inst(inst),
      .inst_pc(inst_pc),
      .inst_ready(inst_ready),
      .jump(jump),
      .jump_addr(jump_addr),
      .stop(stop),
      .halted(halted),
      .retire_cnt(retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
   endtask

   // Transaction-level model: fetch bookkeeping as plain flags and arithmetic.
   logic        m_started, m_out, m_have, m_halted;
   logic [31:0] m_pc, m_inst, m_inst_pc, m_cnt;
   logic        m_req;
   assign m_req = m_started && !m_out && !m_have && !m_halted;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_started <= 1'b0; m_out <= 1'b0; m_have <= 1'b0; m_halted <= 1'b0;
         m_pc <= RST_PC; m_inst <= 32'd0; m_inst_pc <= 32'd0; m_cnt <= 32'd0;
      end else if (!m_started) begin
         m_started <= 1'b1;
      end else if (!m_halted) begin
         if (m_req && mem_req_ready) begin
            m_out <= 1'b1;
         end else if (m_out) begin
            if (mem_resp_valid) begin
               m_inst <= mem_resp_data; m_inst_pc <= m_pc; m_have <= 1'b1; m_out <= 1'b0;
            end
         end else if (m_have && inst_ready) begin
            m_cnt  <= m_cnt + 32'd1;
            m_have <= 1'b0;
            if (stop) m_halted <= 1'b1;
            else if (jump) m_pc <= jump_addr & 32'hFFFF_FFFC;
            else m_pc <= m_pc + 32'd4;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         check("req_valid", {31'd0, mem_req_valid}, {31'd0, m_req});
         check("req_addr", mem_req_addr, m_pc);
         check("inst_valid", {31'd0, inst_valid}, {31'd0, m_have});
         check("halted", {31'd0, halted}, {31'd0, m_halted});
         check("retire_cnt", retire_cnt, m_cnt);
         if (m_have || !rst) begin
            check("inst", inst, m_inst);
            check("inst_pc", inst_pc, m_inst_pc);
         end
      end
   end

   // Memory responder: a falling req_valid outside reset marks a handshake; answer after 0..max_extra cycles.
   logic        pending, prev_v;
   int          lat;
   logic [31:0] last_addr;
   initial begin
      mem_resp_valid = 1'b0; mem_resp_data = 32'd0;
      pending = 1'b0; prev_v = 1'b0; lat = 0; last_addr = 32'd0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            pending = 1'b0; prev_v = 1'b0; mem_resp_valid = 1'b0;
         end else begin
            if (prev_v && !mem_req_valid && !pending) begin
               pending = 1'b1;
               lat = $urandom_range(0, max_extra);
            end
            prev_v = mem_req_valid;
            if (mem_req_valid) last_addr = mem_req_addr;
            if (pending) begin
               if (lat == 0) begin
                  mem_resp_valid = 1'b1; mem_resp_data = mem_word(last_addr); pending = 1'b0;
               end else begin
                  lat--; mem_resp_valid = 1'b0;
               end
            end else begin
               mem_resp_valid = spur_en && ($urandom % 2 == 0);
               mem_resp_data  = $urandom;
            end
         end
      end
   end

   task automatic wait_inst();
      int n = 0;
      while (!inst_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!inst_valid) begin
         n_total++;
         $display("FAIL wait_inst: inst_valid still %b after 60 cycles, required 1", inst_valid);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_req_valid"}, {31'd0, mem_req_valid}, 32'd0);
      check({tag, "_req_addr"}, mem_req_addr, 32'h8000_0000);
      check({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
      check({tag, "_inst"}, inst, 32'd0);
      check({tag, "_inst_pc"}, inst_pc, 32'd0);
      check({tag, "_halted"}, {31'd0, halted}, 32'd0);
      check({tag, "_retire"}, retire_cnt, 32'd0);
   endtask

   initial begin
      rst = 1'b0; mem_req_ready = 1'b0; inst_ready = 1'b0; jump = 1'b0;
      jump_addr = 32'd0; stop = 1'b0; spur_en = 1'b0; max_extra = 0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");

      // Reset release and sequential stream, best-case timing.
      mem_req_ready = 1'b1; inst_ready = 1'b1; rst = 1'b1;
      @(negedge clk);
      check("first_req_valid", {31'd0, mem_req_valid}, 32'd1);
      check("first_req_addr", mem_req_addr, 32'h8000_0000);
      repeat (2) @(negedge clk);
      check("first_inst_valid", {31'd0, inst_valid}, 32'd1);
      check("first_inst_pc", inst_pc, 32'h8000_0000);
      check("first_inst", inst, mem_word(32'h8000_0000));
      for (int i = 1; i < 5; i++) begin
         repeat (3) @(negedge clk);
         check("seq_inst_valid", {31'd0, inst_valid}, 32'd1);
         check("seq_inst_pc", inst_pc, 32'h8000_0000 + 32'(4 * i));
      end
      @(negedge clk);
      check("seq_retire", retire_cnt, 32'd5);
      check("model_retire", m_cnt, 32'd5);
      check("seq_next_addr", mem_req_addr, 32'h8000_0014);

      // Request backpressure, then decode backpressure with an unaccepted jump.
      mem_req_ready = 1'b0; inst_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_req_valid", {31'd0, mem_req_valid}, 32'd1);
         check("bp_req_addr", mem_req_addr, 32'h8000_0014);
      end
      mem_req_ready = 1'b1;
      repeat (2) @(negedge clk);
      jump = 1'b1; jump_addr = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         check("hold_inst_valid", {31'd0, inst_valid}, 32'd1);
         check("hold_inst_pc", inst_pc, 32'h8000_0014);
         check("hold_inst", inst, mem_word(32'h8000_0014));
         check("hold_no_req", {31'd0, mem_req_valid}, 32'd0);
         @(negedge clk);
      end

      // Redirect on accept, then wrap at the top of the address space.
      inst_ready = 1'b1; jump_addr = 32'h8000_0103;
      @(negedge clk);
      check("redir_addr", mem_req_addr, 32'h8000_0100);
      check("redir_valid", {31'd0, mem_req_valid}, 32'd1);
      check("redir_retire", retire_cnt, 32'd6);
      jump = 1'b0;
      wait_inst();
      check("redir_inst_pc", inst_pc, 32'h8000_0100);
      jump = 1'b1; jump_addr = 32'hFFFF_FFFF;
      @(negedge clk);
      check("top_addr", mem_req_addr, 32'hFFFF_FFFC);
      jump = 1'b0;
      wait_inst();
      check("top_inst_pc", inst_pc, 32'hFFFF_FFFC);
      @(negedge clk);
      check("wrap_addr", mem_req_addr, 32'h0000_0000);

      // Reset while a request is outstanding.
      @(negedge clk);
      check("wait_no_req", {31'd0, mem_req_valid}, 32'd0);
      #2 rst = 1'b0;
      #1 check_reset_vals("midrst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("restart_valid", {31'd0, mem_req_valid}, 32'd1);
      check("restart_addr", mem_req_addr, 32'h8000_0000);

      // Randomized traffic with spurious responses and occasional resets.
      spur_en = 1'b1; max_extra = 3;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (c % 1000 == 500) begin
            #2 rst = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
         end
         mem_req_ready = ($urandom % 4) != 0;
         inst_ready    = ($urandom % 3) != 0;
         jump          = ($urandom % 2) != 0;
         jump_addr     = $urandom;
      end

      // Stop with jump also set: stop wins, then fetch stays dead.
      spur_en = 1'b0; max_extra = 0; mem_req_ready = 1'b1;
      inst_ready = 1'b0; jump = 1'b0;
      @(negedge clk);
      wait_inst();
      inst_ready = 1'b1; stop = 1'b1; jump = 1'b1; jump_addr = 32'h8000_0200;
      @(negedge clk);
      check("stop_halted", {31'd0, halted}, 32'd1);
      check("stop_no_inst", {31'd0, inst_valid}, 32'd0);
      check("stop_no_req", {31'd0, mem_req_valid}, 32'd0);
      inst_ready = 1'b0; stop = 1'b0; jump = 1'b0; spur_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("halt_halted", {31'd0, halted}, 32'd1);
         check("halt_no_req", {31'd0, mem_req_valid}, 32'd0);
         check("halt_no_inst", {31'd0, inst_valid}, 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
